// File: rtl/div_sequencer_pkg.sv
// Shared constants and state encodings for the iterative divider sequencer.
package div_sequencer_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Start/busy/done handshake and operand/result bundle between E stage and the divider.
interface div_sequencer_if
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cancel;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_div, opa, opb, cancel,
    input  busy, result_valid, quotient, remainder
  );

  modport slave (
    input  start, signed_div, opa, opb, cancel,
    output busy, result_valid, quotient, remainder
  );
endinterface

// File: rtl/div_sequencer_step.sv
// One restoring division iteration: shift {rem,quo} left, subtract divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = shifted >= {1'b0, divisor};
  // When the divisor fits the true difference is below divisor, so the low bits are exact.
  assign trial   = shifted[WIDTH-1:0] - divisor;
  assign remNext = fits ? trial : shifted[WIDTH-1:0];
  assign quoNext = {quo[WIDTH-2:0], fits};
endmodule

// File: rtl/div_sequencer.sv
// Sequences DIV/DIVU through the shared restoring divider; busy stalls the pipeline.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            resetn,
  div_sequencer_if.slave bus
);
  divState_t        state;
  logic [WIDTH-1:0] remReg, quoReg, divisorReg;
  logic [WIDTH-1:0] quotientReg, remainderReg;
  logic [CNT_W-1:0] countReg;
  logic             aNegReg, bNegReg, signedReg, divZeroReg;
  logic             accept;
  logic             aNeg, bNeg;
  logic [WIDTH-1:0] stepRem, stepQuo, fixQuo, fixRem;

  assign accept = (state != DIV_BUSY) && bus.start && !bus.cancel;
  assign aNeg   = bus.signed_div && bus.opa[WIDTH-1];
  assign bNeg   = bus.signed_div && bus.opb[WIDTH-1];

  assign bus.busy         = !bus.cancel && ((state == DIV_BUSY) || accept);
  assign bus.result_valid = !bus.cancel && (state == DIV_DONE);
  assign bus.quotient     = quotientReg;
  assign bus.remainder    = remainderReg;

  div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (remReg),
    .quo     (quoReg),
    .divisor (divisorReg),
    .remNext (stepRem),
    .quoNext (stepQuo)
  );

  // Remainder sign fix also restores the raw dividend for divide-by-zero.
  assign fixQuo = divZeroReg ? '1 :
                  (signedReg && (aNegReg ^ bNegReg)) ? -stepQuo : stepQuo;
  assign fixRem = (signedReg && aNegReg) ? -stepRem : stepRem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= DIV_IDLE;
      remReg       <= '0;
      quoReg       <= '0;
      divisorReg   <= '0;
      quotientReg  <= '0;
      remainderReg <= '0;
      countReg     <= '0;
      aNegReg      <= 1'b0;
      bNegReg      <= 1'b0;
      signedReg    <= 1'b0;
      divZeroReg   <= 1'b0;
    end else if (bus.cancel) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE, DIV_DONE: begin
          if (accept) begin
            remReg     <= '0;
            quoReg     <= aNeg ? -bus.opa : bus.opa;
            divisorReg <= bNeg ? -bus.opb : bus.opb;
            aNegReg    <= aNeg;
            bNegReg    <= bNeg;
            signedReg  <= bus.signed_div;
            divZeroReg <= (bus.opb == '0);
            countReg   <= '0;
            state      <= DIV_BUSY;
          end else begin
            state <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          remReg   <= stepRem;
          quoReg   <= stepQuo;
          countReg <= countReg + CNT_W'(1);
          if (countReg == CNT_W'(WIDTH - 1)) begin
            quotientReg  <= fixQuo;
            remainderReg <= fixRem;
            state        <= DIV_DONE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule
